issue_sched: RTL and testbench
==============================

# issue_sched

In-order-age issue scheduler that sits between rename and `dispatch`. It buffers up to DEPTH renamed ops and tracks source-operand readiness through writeback and single-cycle ALU-forward wakeups. Each cycle it presents the oldest ready op whose pipe is free, together with the `src*_forward_alu` selects that `dispatch` consumes. A branch-commit override flushes the whole buffer.

## Interface
- DEPTH, 4: entry count, 2..8
- PAYLOAD_W, 96: opaque per-op payload (pc, imm, fid, cmds, bp info) passed through unchanged
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bco_valid  in  1  flush all entries
- i_valid  in  1  enqueue request
- i_ready  out  1  enqueue accept; equals (count < DEPTH)
- i_payload  in  PAYLOAD_W  op payload
- i_pipe  in  4  one-hot target pipe {bru,mem,mul,alu}
- i_dst_rob  in  4  destination ROB tag
- i_src0_rdy, i_src1_rdy  in  1 each  source already available at rename
- i_src0_rob, i_src1_rob  in  4 each  source producer tags
- i_wb_valid  in  1  writeback wakeup
- i_wb_rob  in  4  writeback tag
- i_mul_busy, i_mem_busy  in  1 each  pipe cannot accept this cycle
- o_valid  out  1  issue offer
- o_ready  in  1  dispatch accepts
- o_payload  out  PAYLOAD_W;  o_pipe  out  4;  o_dst_rob  out  4
- o_src0_forward_alu, o_src1_forward_alu  out  1 each  source comes from ALU forward this cycle
- o_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entries form a compacting queue: index 0 is oldest, and enqueue writes at index `count`.
- Per-source state: `rdy` (sticky), `fwd` (one-cycle), `rob`.
- Source is usable when `rdy | fwd`.
- An entry is eligible when both sources are usable and its pipe is free:
  - alu and bru pipes are always free.
  - mul is free when `!i_mul_busy`.
  - mem is free when `!i_mem_busy`.
- Selection: the lowest-index eligible entry wins.
  - `o_valid` = an eligible entry exists and `!bco_valid`.
  - Outputs reflect the selected entry combinationally.
- Issue fires when `o_valid & o_ready`. The chosen entry is removed, and entries above it shift down by one at the clock edge.
- Writeback wakeup: when `i_wb_valid` is high, every source with `rob == i_wb_rob` sets `rdy` at the next edge. This includes an op enqueued in the same cycle.
- ALU-forward wakeup: when an alu-pipe op issues with dst X, every non-`rdy` source with `rob == X` sets `fwd` for the next cycle only. This includes an op enqueued in the same cycle.
  - `fwd` clears after one cycle whether or not the consumer issued.
  - A source that reverts to not-ready waits for the writeback wakeup.
- `o_srcN_forward_alu` = `fwd & !rdy` of the selected entry's source N.
- Flush: `bco_valid` empties the queue at the edge.
  - Same-cycle enqueue is dropped and no issue fires.
  - `reset` has priority over `bco_valid`.
- Enqueue and issue may occur in the same cycle; count is unchanged. The new op lands at index `count-1` after the shift.
- No enqueue while full, even if an issue fires that cycle; `i_ready` has no combinational path from `o_ready`.

## Timing
- Reset values: count 0, all `rdy`/`fwd` 0, `o_valid` 0, `i_ready` 1, `o_count` 0. Payload registers are not reset.
- Minimum latency enqueue→offer is 1 cycle when sources are ready at rename.
- A writeback in cycle t makes a dependant eligible in cycle t+1.
- An ALU producer issued in cycle t lets its consumer issue in cycle t+1 with forward=1.
- `o_count` and `i_ready` are derived from registered state only.

## Structure
- Shared package `core_pkg`:
  - `ROB_W` = 4
  - pipe one-hot bit constants `PIPE_ALU`, `PIPE_MUL`, `PIPE_MEM`, `PIPE_BRU`
- Sub-module `issue_sched_entry`, one per index: holds the source state, performs the wakeup compare, and produces the eligible signal. The shift and priority select stay in the top module.

## Test plan
- Reset, then enqueue A (alu, srcs rdy) → `o_valid` next cycle; `o_ready`=1 → `o_count` 1→0, `o_src*_forward_alu`=0.
- Enqueue A (alu, dst 3), then B (src0_rob 3, not rdy); issue A in cycle t → B offered in t+1 with `o_src0_forward_alu`=1.
- Same as above with `o_ready`=0 in t+1 → B not offered in t+2; `i_wb_valid`, rob 3 in t+2 → B offered in t+3 with forward=0.
- Fill 4 entries, all ready; oldest is mul with `i_mul_busy`=1 → index 1 issued, and the queue compacts in the correct order. `i_ready`=0 while count is 4.
- 3 entries queued plus a simultaneous enqueue, with `bco_valid`=1 → next cycle count 0, `o_valid`=0, and the new op is absent.
- Enqueue and issue in the same cycle at count 2 → count stays 2, and age order is preserved on subsequent issues.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: ROB tag width, one-hot pipe codes, and the
// per-source wakeup state carried by issue queue entries.
package core_pkg;

  localparam int unsigned ROB_W = 4;

  localparam logic [3:0] PIPE_ALU = 4'b0001;
  localparam logic [3:0] PIPE_MUL = 4'b0010;
  localparam logic [3:0] PIPE_MEM = 4'b0100;
  localparam logic [3:0] PIPE_BRU = 4'b1000;

  typedef struct packed {
    logic             rdy;
    logic             fwd;
    logic [ROB_W-1:0] rob;
  } src_t;

  function automatic logic pipe_free(input logic [3:0] pipe,
                                     input logic       mul_busy,
                                     input logic       mem_busy);
    return !((|(pipe & PIPE_MUL)) && mul_busy) && !((|(pipe & PIPE_MEM)) && mem_busy);
  endfunction

  // fwd is evaluated against the pre-writeback rdy so it only ever marks
  // sources that were still waiting when the ALU producer issued.
  function automatic src_t src_wake(input src_t             s,
                                    input logic             wb_valid,
                                    input logic [ROB_W-1:0] wb_rob,
                                    input logic             fwd_valid,
                                    input logic [ROB_W-1:0] fwd_rob);
    src_t r;
    r.rob = s.rob;
    r.rdy = s.rdy || (wb_valid && (s.rob == wb_rob));
    r.fwd = !s.rdy && fwd_valid && (s.rob == fwd_rob);
    return r;
  endfunction

endpackage

// File: rtl/issue_sched_entry.sv
// One issue queue slot's source-operand state: loads a shifted or new op,
// applies writeback/forward wakeups, and reports issue eligibility.
module issue_sched_entry
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  src_t             ld_src0,
  input  src_t             ld_src1,
  input  logic             valid,
  input  logic [3:0]       pipe,
  input  logic             mul_busy,
  input  logic             mem_busy,
  input  logic             wb_valid,
  input  logic [ROB_W-1:0] wb_rob,
  input  logic             fwd_valid,
  input  logic [ROB_W-1:0] fwd_rob,
  output src_t             src0,
  output src_t             src1,
  output logic             eligible
);

  src_t src0_q, src0_d;
  src_t src1_q, src1_d;

  always_comb begin
    src0_d = src_wake(load ? ld_src0 : src0_q, wb_valid, wb_rob, fwd_valid, fwd_rob);
    src1_d = src_wake(load ? ld_src1 : src1_q, wb_valid, wb_rob, fwd_valid, fwd_rob);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src0_q <= '0;
      src1_q <= '0;
    end else begin
      src0_q <= src0_d;
      src1_q <= src1_d;
    end
  end

  assign src0     = src0_q;
  assign src1     = src1_q;
  assign eligible = valid && (src0_q.rdy || src0_q.fwd) && (src1_q.rdy || src1_q.fwd)
                    && pipe_free(pipe, mul_busy, mem_busy);

endmodule

// File: rtl/issue_sched.sv
// Age-ordered compacting issue queue: offers the oldest eligible op to
// dispatch with ALU-forward selects, and flushes on branch-commit override.
module issue_sched
  import core_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = 96,
  localparam int unsigned CW       = $clog2(DEPTH + 1),
  localparam int unsigned IW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bco_valid,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic [3:0]           i_pipe,
  input  logic [ROB_W-1:0]     i_dst_rob,
  input  logic                 i_src0_rdy,
  input  logic                 i_src1_rdy,
  input  logic [ROB_W-1:0]     i_src0_rob,
  input  logic [ROB_W-1:0]     i_src1_rob,
  input  logic                 i_wb_valid,
  input  logic [ROB_W-1:0]     i_wb_rob,
  input  logic                 i_mul_busy,
  input  logic                 i_mem_busy,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [3:0]           o_pipe,
  output logic [ROB_W-1:0]     o_dst_rob,
  output logic                 o_src0_forward_alu,
  output logic                 o_src1_forward_alu,
  output logic [CW-1:0]        o_count
);

  logic [CW-1:0]        count_q, count_d, wr_idx;
  logic [PAYLOAD_W-1:0] pl_q   [DEPTH];
  logic [PAYLOAD_W-1:0] pl_d   [DEPTH];
  logic [3:0]           pipe_q [DEPTH];
  logic [3:0]           pipe_d [DEPTH];
  logic [ROB_W-1:0]     dst_q  [DEPTH];
  logic [ROB_W-1:0]     dst_d  [DEPTH];
  src_t                 src0   [DEPTH];
  src_t                 src1   [DEPTH];
  src_t                 ld0    [DEPTH];
  src_t                 ld1    [DEPTH];
  logic [DEPTH-1:0]     load, vld, elig;
  logic                 sel_found, fire, enq, fwd_valid;
  logic [IW-1:0]        sel_idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    issue_sched_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .ld_src0   (ld0[g]),
      .ld_src1   (ld1[g]),
      .valid     (vld[g]),
      .pipe      (pipe_q[g]),
      .mul_busy  (i_mul_busy),
      .mem_busy  (i_mem_busy),
      .wb_valid  (i_wb_valid),
      .wb_rob    (i_wb_rob),
      .fwd_valid (fwd_valid),
      .fwd_rob   (o_dst_rob),
      .src0      (src0[g]),
      .src1      (src1[g]),
      .eligible  (elig[g])
    );
  end

  always_comb begin
    vld = '0;
    for (int unsigned i = 0; i < DEPTH; i++) vld[i] = CW'(i) < count_q;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && elig[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign i_ready            = count_q < CW'(DEPTH);
  assign o_count            = count_q;
  assign o_valid            = sel_found && !bco_valid;
  assign o_payload          = pl_q[sel_idx];
  assign o_pipe             = pipe_q[sel_idx];
  assign o_dst_rob          = dst_q[sel_idx];
  assign o_src0_forward_alu = src0[sel_idx].fwd && !src0[sel_idx].rdy;
  assign o_src1_forward_alu = src1[sel_idx].fwd && !src1[sel_idx].rdy;
  assign fire               = o_valid && o_ready;
  assign enq                = i_valid && i_ready && !bco_valid;
  assign fwd_valid          = fire && (|(o_pipe & PIPE_ALU));

  // Slots at or above the issued index take their upper neighbour; a new op
  // lands at count minus the issue so it sits directly above the survivors.
  always_comb begin
    wr_idx  = count_q - CW'(fire);
    count_d = bco_valid ? '0 : count_q + CW'(enq) - CW'(fire);
    load    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ld0[i]    = src0[i];
      ld1[i]    = src1[i];
      pl_d[i]   = pl_q[i];
      pipe_d[i] = pipe_q[i];
      dst_d[i]  = dst_q[i];
      if (enq && (wr_idx == CW'(i))) begin
        load[i]   = 1'b1;
        ld0[i]    = '{rdy: i_src0_rdy, fwd: 1'b0, rob: i_src0_rob};
        ld1[i]    = '{rdy: i_src1_rdy, fwd: 1'b0, rob: i_src1_rob};
        pl_d[i]   = i_payload;
        pipe_d[i] = i_pipe;
        dst_d[i]  = i_dst_rob;
      end
    end
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      if (fire && (IW'(i) >= sel_idx) && !(enq && (wr_idx == CW'(i)))) begin
        load[i]   = 1'b1;
        ld0[i]    = src0[i+1];
        ld1[i]    = src1[i+1];
        pl_d[i]   = pl_q[i+1];
        pipe_d[i] = pipe_q[i+1];
        dst_d[i]  = dst_q[i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pl_q[i]   <= pl_d[i];
      pipe_q[i] <= pipe_d[i];
      dst_q[i]  <= dst_d[i];
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
// Randomized and directed stimulus for issue_sched, checked each cycle
// against an age-ordered queue model of the scheduler.
module tb_issue_sched;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 96;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, bco_valid, i_valid, i_ready;
  logic [PW-1:0] i_payload;
  logic [3:0]    i_pipe, i_dst_rob, i_src0_rob, i_src1_rob, i_wb_rob;
  logic          i_src0_rdy, i_src1_rdy, i_wb_valid, i_mul_busy, i_mem_busy;
  logic          o_valid, o_ready, o_src0_forward_alu, o_src1_forward_alu;
  logic [PW-1:0] o_payload;
  logic [3:0]    o_pipe, o_dst_rob;
  logic [CW-1:0] o_count;

  always #5 clk = ~clk;

  issue_sched #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset), .bco_valid(bco_valid),
    .i_valid(i_valid), .i_ready(i_ready), .i_payload(i_payload), .i_pipe(i_pipe),
    .i_dst_rob(i_dst_rob), .i_src0_rdy(i_src0_rdy), .i_src1_rdy(i_src1_rdy),
    .i_src0_rob(i_src0_rob), .i_src1_rob(i_src1_rob),
    .i_wb_valid(i_wb_valid), .i_wb_rob(i_wb_rob),
    .i_mul_busy(i_mul_busy), .i_mem_busy(i_mem_busy),
    .o_valid(o_valid), .o_ready(o_ready), .o_payload(o_payload), .o_pipe(o_pipe),
    .o_dst_rob(o_dst_rob), .o_src0_forward_alu(o_src0_forward_alu),
    .o_src1_forward_alu(o_src1_forward_alu), .o_count(o_count)
  );

  typedef struct {
    logic [PW-1:0] pl;
    logic [3:0]    pipe, dst, s0, s1;
    logic          r0, f0, r1, f1;
  } op_t;

  op_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_elig(input op_t e);
    logic free;
    free = !((e.pipe == PIPE_MUL) && i_mul_busy) && !((e.pipe == PIPE_MEM) && i_mem_busy);
    return (e.r0 || e.f0) && (e.r1 || e.f1) && free;
  endfunction

  task automatic cycle();
    int         sel;
    logic       ev, fire, enq, fv;
    logic [3:0] ft;
    op_t        n;
    @(negedge clk);
    sel = -1;
    foreach (q[k]) if (sel < 0 && model_elig(q[k])) sel = k;
    ev = (sel >= 0) && !bco_valid;
    check("o_valid", 128'(o_valid), 128'(ev));
    check("o_count", 128'(o_count), 128'(q.size()));
    check("i_ready", 128'(i_ready), 128'(q.size() < DEPTH));
    if (ev) begin
      check("o_payload", 128'(o_payload), 128'(q[sel].pl));
      check("o_pipe", 128'(o_pipe), 128'(q[sel].pipe));
      check("o_dst_rob", 128'(o_dst_rob), 128'(q[sel].dst));
      check("fwd0", 128'(o_src0_forward_alu), 128'(q[sel].f0 && !q[sel].r0));
      check("fwd1", 128'(o_src1_forward_alu), 128'(q[sel].f1 && !q[sel].r1));
    end
    @(posedge clk);
    if (reset || bco_valid) begin
      q.delete();
    end else begin
      fire = ev && o_ready;
      fv   = fire && (q[sel].pipe == PIPE_ALU);
      ft   = fire ? q[sel].dst : 4'd0;
      enq  = i_valid && (q.size() < DEPTH);
      if (fire) q.delete(sel);
      if (enq) begin
        n.pl = i_payload; n.pipe = i_pipe; n.dst = i_dst_rob;
        n.s0 = i_src0_rob; n.r0 = i_src0_rdy; n.f0 = 1'b0;
        n.s1 = i_src1_rob; n.r1 = i_src1_rdy; n.f1 = 1'b0;
        q.push_back(n);
      end
      foreach (q[k]) begin
        q[k].f0 = !q[k].r0 && fv && (q[k].s0 == ft);
        q[k].f1 = !q[k].r1 && fv && (q[k].s1 == ft);
        q[k].r0 = q[k].r0 || (i_wb_valid && (q[k].s0 == i_wb_rob));
        q[k].r1 = q[k].r1 || (i_wb_valid && (q[k].s1 == i_wb_rob));
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; bco_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    i_wb_valid = 1'b0; i_wb_rob = 4'd0; i_mul_busy = 1'b0; i_mem_busy = 1'b0;
    i_payload = '0; i_pipe = PIPE_ALU; i_dst_rob = 4'd0;
    i_src0_rdy = 1'b0; i_src1_rdy = 1'b0; i_src0_rob = 4'd0; i_src1_rob = 4'd0;
  endtask

  task automatic put(input logic [3:0] pipe, input logic [3:0] dst,
                     input logic r0, input logic [3:0] s0,
                     input logic r1, input logic [3:0] s1);
    i_valid = 1'b1; i_payload = {$urandom, $urandom, $urandom};
    i_pipe = pipe; i_dst_rob = dst;
    i_src0_rdy = r0; i_src0_rob = s0; i_src1_rdy = r1; i_src1_rob = s1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;

    // single ready ALU op: offered next cycle, then drained
    put(PIPE_ALU, 4'd1, 1, 4'd0, 1, 4'd0); cycle();
    idle(); cycle();
    o_ready = 1'b1; cycle(); cycle();

    // forward wakeup consumed immediately
    idle(); put(PIPE_ALU, 4'd3, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_ALU, 4'd5, 0, 4'd3, 1, 4'd0); cycle();
    idle(); o_ready = 1'b1; cycle(); cycle(); cycle();

    // forward missed, then writeback wakeup
    idle(); put(PIPE_ALU, 4'd3, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_ALU, 4'd6, 0, 4'd3, 1, 4'd0); cycle();
    idle(); o_ready = 1'b1; cycle();
    o_ready = 1'b0; cycle(); cycle();
    i_wb_valid = 1'b1; i_wb_rob = 4'd3; cycle();
    idle(); cycle();
    o_ready = 1'b1; cycle();

    // full queue, mul oldest but busy; enqueue attempt while full
    idle(); put(PIPE_MUL, 4'd8, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_ALU, 4'd9, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_MEM, 4'd10, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_BRU, 4'd11, 1, 4'd0, 1, 4'd0); cycle();
    idle(); cycle();
    put(PIPE_ALU, 4'd12, 1, 4'd0, 1, 4'd0); o_ready = 1'b1; i_mul_busy = 1'b1; cycle();
    idle(); i_mul_busy = 1'b1; cycle();
    idle(); o_ready = 1'b1; repeat (5) cycle();

    // flush with a same-cycle enqueue
    idle(); put(PIPE_ALU, 4'd1, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_MUL, 4'd2, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_MEM, 4'd4, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_BRU, 4'd7, 1, 4'd0, 1, 4'd0); bco_valid = 1'b1; o_ready = 1'b1; cycle();
    idle(); o_ready = 1'b1; cycle(); cycle();

    // enqueue and issue in the same cycle at count 2
    idle(); put(PIPE_ALU, 4'd1, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_BRU, 4'd2, 1, 4'd0, 1, 4'd0); cycle();
    put(PIPE_MEM, 4'd4, 1, 4'd0, 1, 4'd0); o_ready = 1'b1; cycle();
    idle(); o_ready = 1'b1; repeat (4) cycle();

    for (int unsigned c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 599) == 0);
      bco_valid  = ($urandom_range(0, 39) == 0);
      i_valid    = ($urandom_range(0, 9) < 6);
      i_payload  = {$urandom, $urandom, $urandom};
      i_pipe     = 4'(1 << $urandom_range(0, 3));
      i_dst_rob  = 4'($urandom_range(0, 5));
      i_src0_rdy = $urandom_range(0, 1) == 1;
      i_src1_rdy = $urandom_range(0, 2) != 0;
      i_src0_rob = 4'($urandom_range(0, 5));
      i_src1_rob = 4'($urandom_range(0, 5));
      i_wb_valid = ($urandom_range(0, 3) == 0);
      i_wb_rob   = 4'($urandom_range(0, 5));
      i_mul_busy = ($urandom_range(0, 9) < 3);
      i_mem_busy = ($urandom_range(0, 9) < 3);
      o_ready    = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
